// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: instruction-fetch front end holding the PC, driving the external
// PC incrementer and presenting fetched {pc, pc+step, insn} through a 1-entry valid/ready register.
//   clock, reset_n          : rising-edge clock, asynchronous active-low reset
//   add_a, add_b, add_s     : operands to / sum from the downstream ripple-carry incrementer
//   imem_req/addr/ack/rdata : level request fetch port to instruction memory
//   redirect_valid/pc       : decode-stage branch/jump redirect, flushes the output register
//   out_valid/ready/pc/pc_next/insn : output register towards decode
//   stall_cycles            : count of requested-but-unacked cycles (only with FETCH_STALL_COUNT_EN)
module pc_fetch_sequencer #(
    parameter int          PC_WIDTH   = 32,
    parameter int          INSN_WIDTH = 32,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned PC_STEP    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic [PC_WIDTH-1:0]   add_a,
    output logic [PC_WIDTH-1:0]   add_b,
    input  logic [PC_WIDTH-1:0]   add_s,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [INSN_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [PC_WIDTH-1:0]   out_pc_next,
    output logic [INSN_WIDTH-1:0] out_insn
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);
    typedef enum logic [1:0] {BOOT, FETCH, STALL} state_t;
    state_t              state;
    logic [PC_WIDTH-1:0] pc_q;
    logic                accept;
    assign add_a     = pc_q;
    assign add_b     = PC_WIDTH'(PC_STEP);
    assign imem_addr = pc_q;
    // out_ready reaches imem_req combinationally so a draining output can refill in the same cycle
    assign imem_req  = (state == FETCH) && (!out_valid || out_ready);
    assign accept    = imem_req && imem_ack;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BOOT;
            pc_q        <= PC_WIDTH'(RESET_PC);
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_pc_next <= '0;
            out_insn    <= '0;
        end else if (state == BOOT) begin
            state <= FETCH;
        end else if (redirect_valid) begin
            // a same-cycle ack is dropped: no load, no increment
            pc_q      <= redirect_pc;
            out_valid <= 1'b0;
            state     <= FETCH;
        end else if (state == STALL) begin
            if (out_ready) begin
                out_valid <= 1'b0;
                state     <= FETCH;
            end
        end else if (accept) begin
            out_insn    <= imem_rdata;
            out_pc      <= pc_q;
            out_pc_next <= add_s;
            out_valid   <= 1'b1;
            pc_q        <= add_s;
        end else if (!imem_req) begin
            state <= STALL;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
`ifdef FETCH_STALL_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_cycles <= '0;
        else if (imem_req && !imem_ack && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: scoreboard bench for pc_fetch_sequencer.
module tb_pc_fetch_sequencer;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcn;
        logic [31:0] insn;
    } exp_t;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] add_a, add_b, add_s;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_pc_next, out_insn;
`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] mcnt;
`endif
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        q[$];
    logic [31:0] mpc;
    logic        boot;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h5A5A_5A5A;
    endfunction

    assign add_s      = add_a + add_b;
    assign imem_rdata = ins(imem_addr);

    always #5 clock = ~clock;

    pc_fetch_sequencer dut (
        .clock(clock), .reset_n(reset_n),
        .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc_next(out_pc_next), .out_insn(out_insn)
`ifdef FETCH_STALL_COUNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            q.delete();
            mpc  = 32'd0;
            boot = 1'b1;
`ifdef FETCH_STALL_COUNT_EN
            mcnt = 32'd0;
`endif
        end else begin
            vectors++;
            if (imem_addr !== mpc || add_a !== mpc) begin
                miscompares++;
                $display("FAIL sb_addr: imem_addr=%h add_a=%h expected %h", imem_addr, add_a, mpc);
            end
            vectors++;
            if (out_valid !== (q.size() != 0)) begin
                miscompares++;
                $display("FAIL sb_valid: out_valid=%b expected %b", out_valid, q.size() != 0);
            end
`ifdef FETCH_STALL_COUNT_EN
            vectors++;
            if (stall_cycles !== mcnt) begin
                miscompares++;
                $display("FAIL sb_stall_cycles: got %0d expected %0d", stall_cycles, mcnt);
            end
            if (imem_req && !imem_ack && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
`endif
            if (boot) begin
                vectors++;
                if (imem_req !== 1'b0) begin
                    miscompares++;
                    $display("FAIL sb_boot_req: imem_req=%b expected 0", imem_req);
                end
                boot = 1'b0;
            end else begin
                if (out_valid && out_ready && q.size() != 0) begin
                    e = q.pop_front();
                    vectors++;
                    if (out_pc !== e.pc || out_pc_next !== e.pcn || out_insn !== e.insn) begin
                        miscompares++;
                        $display("FAIL sb_out: got pc=%h next=%h insn=%h expected pc=%h next=%h insn=%h",
                                 out_pc, out_pc_next, out_insn, e.pc, e.pcn, e.insn);
                    end
                end
                if (redirect_valid) begin
                    q.delete();
                    mpc = redirect_pc;
                end else if (imem_req && imem_ack) begin
                    q.push_back('{mpc, mpc + 32'd1, ins(mpc)});
                    mpc = mpc + 32'd1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; imem_ack = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clock);
        vectors++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'd0 || add_b !== 32'd1) begin
            miscompares++;
            $display("FAIL reset_ctl: valid=%b req=%b addr=%h add_b=%h expected 0 0 0 1", out_valid, imem_req, imem_addr, add_b);
        end
        vectors++;
        if (out_pc !== 32'd0 || out_pc_next !== 32'd0 || out_insn !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_out: pc=%h next=%h insn=%h expected all 0", out_pc, out_pc_next, out_insn);
        end
    endtask

    task automatic test_sequential;
        tick; reset_n = 1'b1; imem_ack = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_boot: imem_req=%b expected 0", imem_req);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            @(negedge clock);
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(i)) begin
                miscompares++;
                $display("FAIL seq_addr: req=%b addr=%h expected 1 %h", imem_req, imem_addr, 32'(i));
            end
            if (i > 0) begin
                vectors++;
                if (out_valid !== 1'b1 || out_pc !== 32'(i - 1) || out_pc_next !== 32'(i)) begin
                    miscompares++;
                    $display("FAIL seq_out: valid=%b pc=%h next=%h expected 1 %h %h", out_valid, out_pc, out_pc_next, 32'(i - 1), 32'(i));
                end
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] base;
        tick; out_ready = 1'b0; base = mpc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            vectors++;
            if (imem_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== base - 32'd1 ||
                out_pc_next !== base || out_insn !== ins(base - 32'd1)) begin
                miscompares++;
                $display("FAIL stall_hold: req=%b valid=%b pc=%h next=%h insn=%h expected 0 1 %h %h %h",
                         imem_req, out_valid, out_pc, out_pc_next, out_insn, base - 32'd1, base, ins(base - 32'd1));
            end
            tick;
        end
        out_ready = 1'b1;
        @(negedge clock);
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release_req: imem_req=%b expected 0", imem_req);
        end
        tick;
        @(negedge clock);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== base || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_resume: req=%b addr=%h valid=%b expected 1 %h 0", imem_req, imem_addr, out_valid, base);
        end
    endtask

    task automatic test_ack_delay;
`ifdef FETCH_STALL_COUNT_EN
        logic [31:0] sc0;
`endif
        tick; redirect_valid = 1'b1; redirect_pc = 32'd5; imem_ack = 1'b0;
        @(negedge clock);
        tick; redirect_valid = 1'b0;
        @(negedge clock);
`ifdef FETCH_STALL_COUNT_EN
        sc0 = mcnt;
`endif
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick;
                if (i == 3) imem_ack = 1'b1;
                @(negedge clock);
            end
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== 32'd5) begin
                miscompares++;
                $display("FAIL ack_delay_hold: req=%b addr=%h expected 1 5", imem_req, imem_addr);
            end
        end
        tick;
        @(negedge clock);
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'd5 || out_pc_next !== 32'd6 || imem_addr !== 32'd6) begin
            miscompares++;
            $display("FAIL ack_delay_out: valid=%b pc=%h next=%h addr=%h expected 1 5 6 6", out_valid, out_pc, out_pc_next, imem_addr);
        end
`ifdef FETCH_STALL_COUNT_EN
        vectors++;
        if (stall_cycles !== sc0 + 32'd3) begin
            miscompares++;
            $display("FAIL ack_delay_count: stall_cycles=%0d expected %0d", stall_cycles, sc0 + 32'd3);
        end
`endif
    endtask

    task automatic test_redirect;
        tick; redirect_valid = 1'b1; redirect_pc = 32'd7;
        @(negedge clock);
        tick; redirect_pc = 32'h40;
        @(negedge clock);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd7 || imem_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL redirect_pre: req=%b addr=%h expected 1 7", imem_req, imem_addr);
        end
        tick; redirect_valid = 1'b0;
        @(negedge clock);
        vectors++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin
            miscompares++;
            $display("FAIL redirect_flush: valid=%b addr=%h expected 0 40", out_valid, imem_addr);
        end
    endtask

    task automatic test_wrap;
        tick; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        @(negedge clock);
        tick; redirect_valid = 1'b0;
        @(negedge clock);
        vectors++;
        if (imem_addr !== 32'hFFFF_FFFF || imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_addr: addr=%h req=%b expected ffffffff 1", imem_addr, imem_req);
        end
        tick;
        @(negedge clock);
        vectors++;
        if (out_pc !== 32'hFFFF_FFFF || out_pc_next !== 32'd0 || imem_addr !== 32'd0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_out: pc=%h next=%h addr=%h valid=%b expected ffffffff 0 0 1", out_pc, out_pc_next, imem_addr, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 400; i++) begin
            tick;
            imem_ack       = $urandom_range(0, 3) != 0;
            out_ready      = $urandom_range(0, 3) != 0;
            redirect_valid = $urandom_range(0, 15) == 0;
            redirect_pc    = $urandom;
        end
        tick; redirect_valid = 1'b0; imem_ack = 1'b1; out_ready = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        tick; redirect_valid = 1'b1; redirect_pc = 32'h123;
        @(negedge clock);
        tick; redirect_valid = 1'b0;
        @(negedge clock);
        tick;
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'd0 || out_pc !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid: valid=%b req=%b addr=%h pc=%h expected 0 0 0 0", out_valid, imem_req, imem_addr, out_pc);
        end
        @(negedge clock);
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_stall;
        test_ack_delay;
        test_redirect;
        test_wrap;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Instruction-fetch front end of the processor datapath. Holds the program counter and drives the operands of the 32-bit ripple-carry PC incrementer, which sits directly downstream.
- Consumes the incrementer's sum as the next sequential PC.
- Issues req/ack fetches to instruction memory and presents {pc, pc+step, insn} to decode through a 1-entry valid/ready output register. Decode-stage redirects (branch/jump) are taken with flush.

Parameters:
- PC_WIDTH, 32: width of PC, adder operands and memory address.
- INSN_WIDTH, 32: instruction word width.
- RESET_PC, 0: PC value loaded on reset.
- PC_STEP, 1: sequential increment; memory is word-addressed.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- add_a  out  PC_WIDTH  incrementer operand A; always equals pc_q
- add_b  out  PC_WIDTH  incrementer operand B; constant PC_STEP
- add_s  in  PC_WIDTH  incrementer sum; combinational, same cycle; carry-out unused
- imem_req  out  1  fetch request, level
- imem_addr  out  PC_WIDTH  fetch address
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  INSN_WIDTH  fetched instruction
- redirect_valid  in  1  take redirect this cycle
- redirect_pc  in  PC_WIDTH  redirect target
- out_valid  out  1  output register holds a fetched instruction
- out_ready  in  1  decode accepts the output this cycle
- out_pc  out  PC_WIDTH  address of out_insn
- out_pc_next  out  PC_WIDTH  out_pc + PC_STEP, captured from add_s
- out_insn  out  INSN_WIDTH  fetched instruction

Behaviour:
- Reset (reset_n=0, asynchronous):
  - pc_q=RESET_PC, state=BOOT.
  - out_valid=0; out_pc, out_pc_next and out_insn = 0; imem_req=0.
- add_a=pc_q and add_b=PC_STEP combinationally in all states.
- imem_addr=pc_q at all times. It is stable while imem_req=1 and no ack.
- State BOOT: imem_req=0. Always goes to FETCH next cycle, so there is 1 dead cycle after reset release.
- State FETCH:
  - imem_req = !out_valid | out_ready. This is the only combinational path from out_ready.
  - Accept = imem_req & imem_ack. On accept:
    - out_insn<=imem_rdata, out_pc<=pc_q, out_pc_next<=add_s, out_valid<=1.
    - pc_q<=add_s. State stays FETCH.
  - imem_req=1 with no ack: hold pc_q and state. Memory latency is unbounded.
  - imem_req=0 because the output is full and stalled: go to STALL.
- State STALL:
  - imem_req=0.
  - When out_ready=1: out_valid<=0 and go to FETCH.
- Output drain: out_valid & out_ready with no accept the same cycle sets out_valid<=0. A drain and an accept in the same cycle leaves out_valid=1 with the new data (back-to-back, 1 insn/cycle when ack is combinational).
- Redirect (redirect_valid=1, any state except BOOT) has highest priority:
  - pc_q<=redirect_pc, out_valid<=0 (flush), state<=FETCH.
  - An imem_ack in the same cycle is discarded: no output load, no PC increment.
  - imem_req may drop without ack. The memory protocol permits request withdrawal.
- Redirect in BOOT is ignored.
- Wrap-around: pc_q = 2^PC_WIDTH - PC_STEP increments to 0. The carry is discarded, not flagged.
- Output stability: out_pc, out_pc_next and out_insn hold while out_valid & !out_ready.
- Reset mid-fetch: state and outputs clear immediately. The outstanding request is abandoned.

Optional Feature:
- Macro FETCH_STALL_COUNT_EN.
- Defined:
  - Adds output port stall_cycles (out, 32).
  - The counter increments each cycle with imem_req=1 & imem_ack=0 and saturates at 0xFFFFFFFF.
  - Cleared by reset only; redirect does not clear it.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset release, imem_ack tied 1, out_ready tied 1 -> cycle 1 imem_req=0; then imem_addr 0,1,2,3 on consecutive cycles; out_pc 0,1,2 with out_pc_next 1,2,3, one per cycle.
- imem_ack delayed 3 cycles on addr 5 -> imem_addr held at 5 for 4 cycles, pc_q unchanged until ack, then out_pc=5 and out_pc_next=6; with macro, stall_cycles +3.
- out_ready=0 for 4 cycles with out_valid=1 -> STALL, imem_req=0, outputs frozen; out_ready=1 -> next fetch at out_pc_next.
- redirect_valid=1, redirect_pc=0x40 in the same cycle as imem_ack for addr 7 -> insn 7 discarded, out_valid=0 next cycle, next imem_addr=0x40.
- Redirect to 0xFFFFFFFF, ack=1 -> out_pc=0xFFFFFFFF, out_pc_next=0, next imem_addr=0.
- Assert reset_n=0 mid-cycle while imem_req=1 -> out_valid, imem_req=0 and pc_q=RESET_PC immediately, no clock edge needed.
